// File: rtl/alu_seq.sv
// Operand-sequencing stage for the combinational ALU units.
// Loads A into Y and then B from the shared bus. Holds both operands stable for a
// programmable settle window, then captures the muxed ALU result into Z. The
// control unit sees a single start/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned EXEC_CYCLES = 1   // legal range 1..15
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [3:0]       op_out,
  input  logic [WIDTH-1:0] r_in,
  output logic [WIDTH-1:0] z_out,
  output logic             z_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoadB = 2'd1,
    StExec  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Settle-counter reload: the first EXEC cycle counts as one of the window.
  localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zv_q, zv_d;
  logic [3:0]       cnt_q, cnt_d;

  // Next-state and datapath load decisions; every register holds by default.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    b_d     = b_q;
    op_d    = op_q;
    z_d     = z_q;
    zv_d    = zv_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          y_d     = bus_in;
          op_d    = op;
          zv_d    = 1'b0;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        b_d     = bus_in;
        cnt_d   = CntInit;
        state_d = StExec;
      end
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          z_d     = r_in;
          zv_d    = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // start is deliberately not looked at here; a request in this cycle is lost.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= StIdle;
      y_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_q     <= '0;
      zv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
      zv_q    <= zv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign a_out   = y_q;
  assign b_out   = b_q;
  assign op_out  = op_q;
  assign z_out   = z_q;
  assign z_valid = zv_q;

endmodule
